elbeth_lsu: RTL and testbench

ELBETH_LSU -- requirements
Module: elbeth_lsu

---
 rtl/elbeth_lsu_pkg.sv | 40 ++++
 rtl/elbeth_lsu_align.sv | 53 +++++
 rtl/elbeth_lsu.sv | 172 +++++++++++++++++
 tb/tb_elbeth_lsu.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_lsu_pkg.sv
// elbeth_lsu_pkg
// Shared definitions for the Elbeth load/store unit: access-size encodings,
// the FSM state enum, byte-enable base patterns and an alignment helper.
// Ports: none (package).
// Configuration macro used by the LSU: ELBETH_LSU_TIMEOUT_EN.

package elbeth_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // An access is misaligned when its low address bits are not a multiple of
  // its size; the reserved size can never be serviced, so it always counts.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addrLo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addrLo[0];
      SIZE_WORD: mis = |addrLo;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/elbeth_lsu_align.sv
// elbeth_lsu_align
// Purely combinational lane steering for the LSU.
// Ports:
//   size_i      access size (lsu_size_e encoding)
//   addrLo_i    byte offset within the 32-bit word
//   wdata_i     right-justified store data
//   unsigned_i  1 = zero-extend loads, 0 = sign-extend
//   rdata_i     raw memory word
//   byteEn_o    per-byte write enables for a store
//   wlanes_o    store data replicated onto every lane it may occupy
//   load_o      selected load lane, extended to 32 bits

module elbeth_lsu_align
  import elbeth_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] wdata_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byteEn_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] load_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = rdata_i[{addrLo_i, 3'b000} +: 8];
  assign halfSel = rdata_i[{addrLo_i[1], 4'b0000} +: 16];

  // Stores replicate the data so the memory only needs the byte enables to
  // pick the right lane; loads pull the lane back down and extend it.
  always_comb begin
    byteEn_o = BE_WORD;
    wlanes_o = wdata_i;
    load_o   = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        byteEn_o = BE_BYTE << addrLo_i;
        wlanes_o = {4{wdata_i[7:0]}};
        load_o   = {{24{~unsigned_i & byteSel[7]}}, byteSel};
      end
      SIZE_HALF: begin
        byteEn_o = BE_HALF << addrLo_i;
        wlanes_o = {2{wdata_i[15:0]}};
        load_o   = {{16{~unsigned_i & halfSel[15]}}, halfSel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/elbeth_lsu.sv
// elbeth_lsu
// Load/store unit bridging the pipeline request interface to a word-wide
// memory port. One request at a time: IDLE captures, WAIT holds the memory
// port until dmem_ready, DONE pulses completion for one cycle.
// Ports:
//   clk, rst (async, active-low)
//   lsu_valid/lsu_addr/lsu_wdata/lsu_write/lsu_size/lsu_unsigned  request
//   lsu_stall, lsu_done, lsu_rdata, lsu_misaligned, lsu_bus_error  response
//   dmem_enable/dmem_addr/dmem_data_in/dmem_wr                     memory out
//   dmem_data_out/dmem_ready                                       memory in
// Configuration: define ELBETH_LSU_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles with lsu_bus_error; otherwise WAIT is unbounded.

module elbeth_lsu
  import elbeth_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  input  logic                  lsu_write,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic [31:0]           lsu_rdata,
  output logic                  lsu_misaligned,
  output logic                  lsu_bus_error,
  output logic                  dmem_enable,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_data_in,
  output logic [3:0]            dmem_wr,
  input  logic [31:0]           dmem_data_out,
  input  logic                  dmem_ready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("elbeth_lsu: TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_e state_q;
  logic [1:0] size_q;
  logic [1:0] addrLo_q;
  logic       unsigned_q;
  logic       write_q;

  logic [1:0]  alignSize;
  logic [1:0]  alignAddrLo;
  logic        alignUnsigned;
  logic [3:0]  alignByteEn;
  logic [31:0] alignLanes;
  logic [31:0] alignLoad;

  // In IDLE the aligner shapes the incoming store; afterwards it works from
  // the captured request so the load lane matches the issued address.
  assign alignSize     = (state_q == ST_IDLE) ? lsu_size     : size_q;
  assign alignAddrLo   = (state_q == ST_IDLE) ? lsu_addr[1:0] : addrLo_q;
  assign alignUnsigned = (state_q == ST_IDLE) ? lsu_unsigned : unsigned_q;

  elbeth_lsu_align u_align (
    .size_i     (alignSize),
    .addrLo_i   (alignAddrLo),
    .wdata_i    (lsu_wdata),
    .unsigned_i (alignUnsigned),
    .rdata_i    (dmem_data_out),
    .byteEn_o   (alignByteEn),
    .wlanes_o   (alignLanes),
    .load_o     (alignLoad)
  );

  // Gated with rst so every output reads 0 while reset is held.
  assign lsu_stall = rst & ((state_q == ST_WAIT) | ((state_q == ST_IDLE) & lsu_valid));

`ifdef ELBETH_LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] waitCnt_q;
  logic            busError_q;
  assign lsu_bus_error = busError_q;
`else
  assign lsu_bus_error = 1'b0;
`endif

  // Single FSM process; every response and memory-port output is a register
  // so nothing combinational leaks from dmem_data_out to the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      size_q         <= 2'b00;
      addrLo_q       <= 2'b00;
      unsigned_q     <= 1'b0;
      write_q        <= 1'b0;
      lsu_done       <= 1'b0;
      lsu_rdata      <= '0;
      lsu_misaligned <= 1'b0;
      dmem_enable    <= 1'b0;
      dmem_addr      <= '0;
      dmem_data_in   <= '0;
      dmem_wr        <= 4'b0000;
`ifdef ELBETH_LSU_TIMEOUT_EN
      waitCnt_q      <= '0;
      busError_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lsu_valid) begin
            size_q     <= lsu_size;
            addrLo_q   <= lsu_addr[1:0];
            unsigned_q <= lsu_unsigned;
            write_q    <= lsu_write;
            if (is_misaligned(lsu_size, lsu_addr[1:0])) begin
              state_q        <= ST_DONE;
              lsu_done       <= 1'b1;
              lsu_misaligned <= 1'b1;
              lsu_rdata      <= '0;
            end else begin
              state_q      <= ST_WAIT;
              dmem_enable  <= 1'b1;
              dmem_addr    <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_wr      <= lsu_write ? alignByteEn : 4'b0000;
              dmem_data_in <= lsu_write ? alignLanes : 32'd0;
`ifdef ELBETH_LSU_TIMEOUT_EN
              waitCnt_q    <= '0;
`endif
            end
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            state_q      <= ST_DONE;
            lsu_done     <= 1'b1;
            lsu_rdata    <= write_q ? 32'd0 : alignLoad;
            dmem_enable  <= 1'b0;
            dmem_addr    <= '0;
            dmem_data_in <= '0;
            dmem_wr      <= 4'b0000;
          end
`ifdef ELBETH_LSU_TIMEOUT_EN
          // Ready on the last allowed cycle still wins over the abort.
          else if (waitCnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= ST_DONE;
            lsu_done     <= 1'b1;
            busError_q   <= 1'b1;
            lsu_rdata    <= '0;
            dmem_enable  <= 1'b0;
            dmem_addr    <= '0;
            dmem_data_in <= '0;
            dmem_wr      <= 4'b0000;
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state_q        <= ST_IDLE;
          lsu_done       <= 1'b0;
          lsu_misaligned <= 1'b0;
          lsu_rdata      <= '0;
`ifdef ELBETH_LSU_TIMEOUT_EN
          busError_q     <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_lsu.sv
// tb_elbeth_lsu
// Scoreboard bench for elbeth_lsu. Each request pushes its expected response
// (computed from address/size arithmetic) into a queue; a monitor compares
// the memory port and the completion pulse against the queue head.
// Honours ELBETH_LSU_TIMEOUT_EN the same way the design does.

module tb_elbeth_lsu;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  typedef struct {
    logic        mis;
    logic        berr;
    logic        chkData;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [3:0]  wr;
    logic        chkWdat;
    logic [31:0] wdat;
    int          doneCycle;
  } expT;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          lsuValid = 1'b0;
  logic [AW-1:0] lsuAddr = '0;
  logic [31:0]   lsuWdata = '0;
  logic          lsuWrite = 1'b0;
  logic [1:0]    lsuSize = 2'b00;
  logic          lsuUnsigned = 1'b0;
  logic          lsuStall, lsuDone, lsuMisaligned, lsuBusError;
  logic [31:0]   lsuRdata;
  logic          dmemEnable;
  logic [AW-1:0] dmemAddr;
  logic [31:0]   dmemDataIn;
  logic [3:0]    dmemWr;
  logic [31:0]   dmemDataOut = '0;
  logic          dmemReady = 1'b0;

  expT         expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  logic [31:0] memWord = '0;
  int          readyDelay = 0;
  int          waitCnt = 0;

  elbeth_lsu #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_valid      (lsuValid),
    .lsu_addr       (lsuAddr),
    .lsu_wdata      (lsuWdata),
    .lsu_write      (lsuWrite),
    .lsu_size       (lsuSize),
    .lsu_unsigned   (lsuUnsigned),
    .lsu_stall      (lsuStall),
    .lsu_done       (lsuDone),
    .lsu_rdata      (lsuRdata),
    .lsu_misaligned (lsuMisaligned),
    .lsu_bus_error  (lsuBusError),
    .dmem_enable    (dmemEnable),
    .dmem_addr      (dmemAddr),
    .dmem_data_in   (dmemDataIn),
    .dmem_wr        (dmemWr),
    .dmem_data_out  (dmemDataOut),
    .dmem_ready     (dmemReady)
  );

  // Free-running clock and a posedge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: unexpected DUT activity (cycle %0d)", name, cycle);
  endtask

  // Memory responder: ready rises after readyDelay enabled cycles.
  always @(negedge clk) begin
    if (!rst || !dmemEnable) begin
      dmemReady = 1'b0;
      waitCnt   = 0;
    end else if (waitCnt >= readyDelay) begin
      dmemReady   = 1'b1;
      dmemDataOut = memWord;
    end else begin
      dmemReady   = 1'b0;
      dmemDataOut = $urandom;
      waitCnt++;
    end
  end

  // Monitor: memory port against the head entry, completion pops it.
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      if (dmemEnable) begin
        if (expQ.size() == 0) reportFail("spurious_enable");
        else if (expQ[0].mis) reportFail("enable_on_misaligned");
        else begin
          checkOutput("dmem_addr", dmemAddr, expQ[0].addr);
          checkOutput("dmem_wr", 32'(dmemWr), 32'(expQ[0].wr));
          if (expQ[0].chkWdat) checkOutput("dmem_data_in", dmemDataIn, expQ[0].wdat);
        end
      end
      if (lsuDone) begin
        if (expQ.size() == 0) reportFail("spurious_done");
        else begin
          e = expQ.pop_front();
          checkOutput("misaligned", 32'(lsuMisaligned), 32'(e.mis));
          checkOutput("bus_error", 32'(lsuBusError), 32'(e.berr));
          if (e.chkData) checkOutput("rdata", lsuRdata, e.rdata);
          checkOutput("done_cycle", 32'(cycle), 32'(e.doneCycle));
          checkOutput("stall_in_done", 32'(lsuStall), 32'd0);
        end
      end
    end
  end

  // Reference model: alignment from address modulo size, lanes by shifting.
  function automatic expT buildExp(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic write, input logic [1:0] size,
                                   input logic uns, input logic [31:0] mem,
                                   input int delay);
    expT    e;
    int     nBytes;
    int     lane;
    int     waits;
    longint mask;
    longint val;
    nBytes = 1 << size;
    lane   = int'(addr % 4);
    e.mis  = (size == 2'd3) || ((addr % nBytes) != 0);
    e.berr = 1'b0;
    e.addr = addr - lane;
    e.wr   = write ? 4'(((1 << nBytes) - 1) << lane) : 4'd0;
    case (size)
      2'd0:    e.wdat = wdata[7:0] * 32'h01010101;
      2'd1:    e.wdat = wdata[15:0] * 32'h00010001;
      default: e.wdat = wdata;
    endcase
    e.chkWdat = write;
    mask = (64'd1 << (8 * nBytes)) - 1;
    val  = (longint'(mem) >> (8 * lane)) & mask;
    if (!uns && nBytes < 4 && val[8*nBytes-1]) val = val | ~mask;
    e.rdata   = e.mis ? 32'd0 : val[31:0];
    e.chkData = !write || e.mis;
    waits = delay + 1;
`ifdef ELBETH_LSU_TIMEOUT_EN
    if (waits > TO) begin
      waits     = TO;
      e.berr    = 1'b1;
      e.rdata   = 32'd0;
      e.chkData = 1'b1;
    end
`endif
    e.doneCycle = cycle + 1 + (e.mis ? 0 : waits);
    return e;
  endfunction

  // Issues one request at negedge+1 from IDLE and returns once it has completed.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic write, input logic [1:0] size,
                               input logic uns, input logic [31:0] mem,
                               input int delay, input logic dropEarly);
    bit seen;
    expQ.push_back(buildExp(addr, wdata, write, size, uns, mem, delay));
    memWord     = mem;
    readyDelay  = delay;
    lsuAddr     = addr;
    lsuWdata    = wdata;
    lsuWrite    = write;
    lsuSize     = size;
    lsuUnsigned = uns;
    lsuValid    = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk); #1;
      if (n == 0 && dropEarly) lsuValid = 1'b0;
      if (!lsuStall) begin
        lsuValid = 1'b0;
        seen     = 1'b1;
      end
    end
    lsuValid = 1'b0;
    @(negedge clk); #1;
    checkOutput("completed", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_enable"}, 32'(dmemEnable), 32'd0);
    checkOutput({tag, "_stall"}, 32'(lsuStall), 32'd0);
    checkOutput({tag, "_done"}, 32'(lsuDone), 32'd0);
    checkOutput({tag, "_wr"}, 32'(dmemWr), 32'd0);
    checkOutput({tag, "_addr"}, dmemAddr, 32'd0);
    checkOutput({tag, "_rdata"}, lsuRdata, 32'd0);
    checkOutput({tag, "_misaligned"}, 32'(lsuMisaligned), 32'd0);
    checkOutput({tag, "_bus_error"}, 32'(lsuBusError), 32'd0);
  endtask

  task automatic applyResetMidWait();
    expQ.push_back(buildExp(32'h100, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 32'h0, 10));
    memWord    = 32'h0;
    readyDelay = 10;
    lsuAddr    = 32'h100;
    lsuWdata   = 32'hCAFEF00D;
    lsuWrite   = 1'b1;
    lsuSize    = 2'd2;
    lsuValid   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst      = 1'b0;
    lsuValid = 1'b0;
    #1;
    checkResetOutputs("midwait_reset");
    expQ.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin : main
    logic [1:0] sz;
    int         dly;
    $display("[TB] elbeth_lsu scoreboard bench starting");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b1;
    @(negedge clk); #1;

    applyStimulus(32'h0000000C, 32'h12345678, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1'b0);
    applyStimulus(32'h00000009, 32'h0, 1'b0, 2'd0, 1'b0, 32'h00008000, 0, 1'b0);
    applyStimulus(32'h00000009, 32'h0, 1'b0, 2'd0, 1'b1, 32'h00008000, 0, 1'b0);
    applyStimulus(32'h00000002, 32'h00000014, 1'b1, 2'd1, 1'b0, 32'h0, 0, 1'b0);
    applyStimulus(32'h00000003, 32'h0, 1'b0, 2'd2, 1'b0, 32'h11223344, 0, 1'b0);
    applyStimulus(32'h00000005, 32'h0, 1'b0, 2'd1, 1'b0, 32'h11223344, 0, 1'b0);
    applyStimulus(32'h00000004, 32'h0, 1'b0, 2'd3, 1'b0, 32'h11223344, 0, 1'b0);
    applyStimulus(32'h00000042, 32'h0, 1'b0, 2'd1, 1'b0, 32'h8001FFFF, 3, 1'b1);
    applyStimulus(32'h00000040, 32'h0, 1'b0, 2'd2, 1'b0, 32'hA5A5A5A5, 15, 1'b0);
    applyStimulus(32'h00000040, 32'h0, 1'b0, 2'd2, 1'b0, 32'hA5A5A5A5, 20, 1'b0);

    applyResetMidWait();
    applyStimulus(32'h00000020, 32'h000000AB, 1'b1, 2'd0, 1'b0, 32'h0, 1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      sz  = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), sz,
                    1'($urandom_range(0, 1)), $urandom, dly,
                    1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so a wedged DUT still reaches the summary line.
  initial begin : watchdog
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached (cycle %0d)", cycle);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
